// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared constants and FSM state encoding for the SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int FRAME_BITS      = 32;
    localparam int CLK_DIV_DEFAULT = 4;
    localparam int CNT_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// ============================================================================
// Module      : spi_clk_gen
// Description : Half-period divider; emits a one-cycle tick at each sck phase end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counter is held at zero outside a frame so every phase starts aligned.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last_cnt) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tick = i_run && (r_cnt == c_last_cnt);

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module      : spi_master
// Description : 32-bit SPI master, sck idle low, sdo on falling / sdi on rising.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master #(
    parameter int CLK_DIV    = spi_pkg::CLK_DIV_DEFAULT,
    parameter int FRAME_BITS = spi_pkg::FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] d,
    input  logic                  sdi,
    output logic                  sck,
    output logic                  sdo,
    output logic [FRAME_BITS-1:0] q,
    output logic                  busy,
    output logic                  done
);

    import spi_pkg::*;

    localparam int                c_bc_w     = $clog2(FRAME_BITS) + 1;
    localparam logic [c_bc_w-1:0] c_last_bit = c_bc_w'(FRAME_BITS - 1);
    localparam logic [c_bc_w-1:0] c_bit_inc  = c_bc_w'(1);

    spi_state_t            r_state;
    logic [FRAME_BITS-1:0] r_tx;
    logic [FRAME_BITS-1:0] r_rx;
    logic [FRAME_BITS-1:0] r_q;
    logic [c_bc_w-1:0]     r_bits;
    logic                  r_sck;
    logic                  r_sdo;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_run;
    logic                  w_tick;

    assign w_run = (r_state == ST_LOW) || (r_state == ST_HIGH);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .rst    (reset),
        .i_run  (w_run),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_q     <= '0;
            r_bits  <= '0;
            r_sck   <= 1'b0;
            r_sdo   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tx    <= d;
                        r_sdo   <= d[FRAME_BITS-1];
                        r_bits  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_tick) begin
                        r_sck   <= 1'b1;
                        r_rx    <= {r_rx[FRAME_BITS-2:0], sdi};
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_tick) begin
                        r_sck  <= 1'b0;
                        r_bits <= r_bits + c_bit_inc;
                        r_tx   <= r_tx << 1;
                        // On the final fall sdo keeps the last transmitted bit.
                        if (r_bits == c_last_bit) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_sdo   <= r_tx[FRAME_BITS-2];
                            r_state <= ST_LOW;
                        end
                    end
                end
                ST_DONE: begin
                    r_q     <= r_rx;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sck  = r_sck;
    assign sdo  = r_sdo;
    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master at CLK_DIV=4 and CLK_DIV=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        st    [2];
    logic [31:0] dd    [2];
    logic        sdi_w [2];
    logic        sck_w [2];
    logic        sdo_w [2];
    logic [31:0] q_w   [2];
    logic        busy_w[2];
    logic        done_w[2];

    logic        lp [2];
    logic [31:0] sw [2];
    int          sidx0 = 0;
    int          sidx1 = 0;

    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    int          rises [2] = '{0, 0};
    logic [31:0] cap   [2] = '{32'd0, 32'd0};
    int          ndone [2] = '{0, 0};
    logic        p_sck [2] = '{1'b0, 1'b0};
    logic        p_sdo [2] = '{1'b0, 1'b0};
    logic        p_busy[2] = '{1'b0, 1'b0};
    logic        p_done[2] = '{1'b0, 1'b0};
    int          run   [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    spi_master #(.CLK_DIV(4)) u_dut0 (
        .clk(clk), .reset(reset), .start(st[0]), .d(dd[0]), .sdi(sdi_w[0]),
        .sck(sck_w[0]), .sdo(sdo_w[0]), .q(q_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    spi_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(st[1]), .d(dd[1]), .sdi(sdi_w[1]),
        .sck(sck_w[1]), .sdo(sdo_w[1]), .q(q_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    // Slave model: presents word MSB first, advancing on each sck fall.
    always @(negedge sck_w[0] or negedge busy_w[0]) begin
        if (!busy_w[0]) sidx0 <= 0;
        else            sidx0 <= sidx0 + 1;
    end
    always @(negedge sck_w[1] or negedge busy_w[1]) begin
        if (!busy_w[1]) sidx1 <= 0;
        else            sidx1 <= sidx1 + 1;
    end
    assign sdi_w[0] = lp[0] ? sdo_w[0] : ((sidx0 < 32) ? sw[0][31 - sidx0] : 1'b0);
    assign sdi_w[1] = lp[1] ? sdo_w[1] : ((sidx1 < 32) ? sw[1][31 - sidx1] : 1'b0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Continuous protocol monitor for both instances.
    always @(posedge clk) begin
        #2;
        for (int g = 0; g < 2; g++) begin
            run[g] = run[g] + 1;
            if (busy_w[g] && !p_busy[g]) begin
                run[g]   = 0;
                rises[g] = 0;
                cap[g]   = '0;
            end
            if ((sck_w[g] !== p_sck[g]) && !reset) begin
                chk($sformatf("sck_tick_dut%0d", g), run[g], div_of(g));
                run[g] = 0;
                if (sck_w[g]) begin
                    rises[g] = rises[g] + 1;
                    cap[g]   = {cap[g][30:0], sdo_w[g]};
                end
            end
            if (p_sck[g] && sck_w[g] && !reset)
                chk($sformatf("sdo_stable_dut%0d", g), sdo_w[g], p_sdo[g]);
            if (done_w[g]) begin
                ndone[g] = ndone[g] + 1;
                chk($sformatf("done_vs_busy_dut%0d", g), busy_w[g], 0);
                chk($sformatf("done_width_dut%0d", g), p_done[g], 0);
            end
            p_sck[g]  = sck_w[g];
            p_sdo[g]  = sdo_w[g];
            p_busy[g] = busy_w[g];
            p_done[g] = done_w[g];
        end
    end

    // Called at a negedge; returns at the negedge on which done is seen.
    task automatic run_frame(input int i, input logic [31:0] dv, input logic loopm,
                             input logic [31:0] sword, input logic pokes, input logic hold,
                             output int t_acc, output int t_done);
        int c;
        int nd0;
        bit got;
        c     = div_of(i);
        lp[i] = loopm;
        sw[i] = sword;
        dd[i] = dv;
        st[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_acc = cyc;
        nd0   = ndone[i];
        chk($sformatf("accept_busy_dut%0d", i), busy_w[i], 1);
        if (!hold) st[i] = 1'b0;
        got    = 1'b0;
        t_done = 0;
        for (int n = 0; n < 64 * c + 16 && !got; n++) begin
            if (pokes) begin
                if (cyc - t_acc == 9 || cyc - t_acc == 255) begin
                    st[i] = 1'b1;
                    dd[i] = ~dv;
                end else begin
                    st[i] = 1'b0;
                end
            end
            @(negedge clk);
            if (done_w[i] === 1'b1) got = 1'b1;
        end
        chk($sformatf("done_seen_dut%0d", i), got, 1);
        if (got) begin
            t_done = cyc;
            chk($sformatf("done_latency_dut%0d", i), cyc - t_acc, 64 * c + 1);
            chk($sformatf("q_dut%0d", i), q_w[i], loopm ? dv : sword);
            chk($sformatf("busy_at_done_dut%0d", i), busy_w[i], 0);
            chk($sformatf("rises_dut%0d", i), rises[i], 32);
            chk($sformatf("sdo_bits_dut%0d", i), cap[i], dv);
            chk($sformatf("done_count_dut%0d", i), ndone[i] - nd0, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, td, ta2, td1, nd;
        logic [31:0] dv;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; dd[i] = '0; lp[i] = 1'b1; sw[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_sck_dut%0d", i),  sck_w[i],  0);
            chk($sformatf("rst_sdo_dut%0d", i),  sdo_w[i],  0);
            chk($sformatf("rst_busy_dut%0d", i), busy_w[i], 0);
            chk($sformatf("rst_done_dut%0d", i), done_w[i], 0);
            chk($sformatf("rst_q_dut%0d", i),    q_w[i],    0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Loopback frame at CLK_DIV=4.
        run_frame(0, 32'hA5A5_0F0F, 1'b1, 32'd0, 1'b0, 1'b0, ta, td);

        // Slave-driven frame at CLK_DIV=1.
        run_frame(1, $urandom, 1'b0, 32'h0000_03FF, 1'b0, 1'b0, ta, td);

        // Extra start pulses and d changes mid-frame are ignored.
        nd = ndone[0];
        run_frame(0, $urandom, 1'b1, 32'd0, 1'b1, 1'b0, ta, td);
        repeat (4) @(negedge clk);
        chk("no_requeue_busy", busy_w[0], 0);
        chk("single_done", ndone[0] - nd, 1);

        // Reset mid-frame aborts, then a fresh frame runs cleanly.
        lp[0] = 1'b1;
        dd[0] = $urandom;
        st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ta    = cyc;
        st[0] = 1'b0;
        nd    = ndone[0];
        while (cyc - ta < 99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_sck",  sck_w[0],  0);
        chk("abort_busy", busy_w[0], 0);
        chk("abort_q",    q_w[0],    0);
        chk("abort_done", done_w[0], 0);
        chk("abort_q_dut1", q_w[1],  0);
        reset = 1'b0;
        dv = $urandom;
        run_frame(0, dv, 1'b1, 32'd0, 1'b0, 1'b0, ta, td);
        chk("abort_no_done", ndone[0] - nd, 1);

        // Start held high: back-to-back frames with one idle cycle.
        run_frame(0, 32'h1, 1'b1, 32'd0, 1'b0, 1'b1, ta, td1);
        run_frame(0, 32'h2, 1'b1, 32'd0, 1'b0, 1'b0, ta2, td);
        chk("btb_gap", ta2 - td1, 1);

        // Randomized frames on both instances.
        for (int n = 0; n < 3; n++)
            run_frame(0, $urandom, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, ta, td);
        for (int n = 0; n < 6; n++)
            run_frame(1, $urandom, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, ta, td);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
